// File: rtl/comp1_agent1_responder.sv
// comp1_agent1_responder
//   Device-side responder on the comp1_agent1 request/response channel.
//   Requests are accepted on a valid/ready handshake and queued in an
//   in-order FIFO. One at a time, the head is popped into a holding
//   register, held for cfg_lat idle cycles, and then returned as a
//   response (data+1, wrap flag) that stays valid until resp_ready.
//
// Ports
//   clk         clock, all logic on posedge
//   rst_n       asynchronous active-low reset
//   req_valid   request valid
//   req_ready   request ready (FIFO not full)
//   req_id      request id
//   req_data    request payload
//   resp_valid  response valid
//   resp_ready  response ready
//   resp_id     id of the request being answered
//   resp_data   req_data + 1, modulo 2^DW
//   resp_err    1 when req_data was all-ones (increment wrapped)
//   resp_par    (COMP1_AGENT1_RESP_PARITY_EN only) ^{resp_id,resp_data,resp_err}
//   cfg_lat     idle cycles between FIFO pop and resp_valid
//   req_cnt     accepted-request counter, wraps 0xFFFF -> 0
//
// Configuration macro: COMP1_AGENT1_RESP_PARITY_EN adds the resp_par output.

module comp1_agent1_responder #(
  parameter int DW    = 8,
  parameter int IDW   = 4,
  parameter int DEPTH = 4,
  parameter int LAT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDW-1:0]   req_id,
  input  logic [DW-1:0]    req_data,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [IDW-1:0]   resp_id,
  output logic [DW-1:0]    resp_data,
  output logic             resp_err,
  input  logic [LAT_W-1:0] cfg_lat,
`ifdef COMP1_AGENT1_RESP_PARITY_EN
  output logic             resp_par,
`endif
  output logic [15:0]      req_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = IDW + DW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // ------------------------------------------------------------------
  // Request FIFO
  // ------------------------------------------------------------------
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;

  logic full;
  logic empty;
  logic push;
  logic pop;

  state_t          state_reg;
  logic [LAT_W-1:0] cnt_reg;

  assign full  = (count_reg == FULL_CNT);
  assign empty = (count_reg == '0);

  // Ready comes from registered occupancy only; a pop in the same cycle
  // does not open the door early. Held low while reset is asserted.
  assign req_ready = rst_n & ~full;
  assign push      = req_valid & req_ready;

  // The FSM pops whenever it is idle, or when the current response is
  // handshaken (back-to-back service).
  assign pop = ~empty & ((state_reg == S_IDLE) |
                         ((state_reg == S_RESP) & resp_ready));

  // Storage array has no reset; only pointers/count define contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {req_id, req_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      req_cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        req_cnt    <= req_cnt + 16'd1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Head decode and response arithmetic
  // ------------------------------------------------------------------
  logic [EW-1:0]  head;
  logic [IDW-1:0] head_id;
  logic [DW-1:0]  head_data;
  logic [DW-1:0]  head_inc;
  logic           head_wrap;

  assign head      = mem[rd_ptr_reg];
  assign head_id   = head[EW-1:DW];
  assign head_data = head[DW-1:0];
  assign head_inc  = head_data + 1'b1;
  assign head_wrap = &head_data;

`ifdef COMP1_AGENT1_RESP_PARITY_EN
  logic head_par;
  assign head_par = ^{head_id, head_inc, head_wrap};
`endif

  // ------------------------------------------------------------------
  // Response FSM. The payload registers double as the holding register:
  // they are loaded at pop and stay frozen until the next pop, so the
  // payload is stable for the whole time resp_valid is high.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
`ifdef COMP1_AGENT1_RESP_PARITY_EN
      resp_par   <= 1'b0;
`endif
    end else begin
      if (pop) begin
        resp_id   <= head_id;
        resp_data <= head_inc;
        resp_err  <= head_wrap;
        // cfg_lat is captured here so later changes only affect later pops.
        cnt_reg   <= cfg_lat;
`ifdef COMP1_AGENT1_RESP_PARITY_EN
        resp_par  <= head_par;
`endif
      end

      case (state_reg)
        S_IDLE: begin
          if (pop) begin
            state_reg <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_reg == '0) begin
            state_reg  <= S_RESP;
            resp_valid <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state_reg  <= pop ? S_WAIT : S_IDLE;
          end
        end
        default: begin
          state_reg  <= S_IDLE;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comp1_agent1_responder.sv
// tb_comp1_agent1_responder
//   Directed testbench for comp1_agent1_responder (default parameters).
//   Inputs are driven 1 ns after the rising edge; outputs are sampled at
//   the same point, away from the active edge.

module tb_comp1_agent1_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_id = '0;
  logic [7:0] req_data = '0;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic [3:0] resp_id;
  logic [7:0] resp_data;
  logic       resp_err;
  logic [3:0] cfg_lat = '0;
  logic [15:0] req_cnt;
`ifdef COMP1_AGENT1_RESP_PARITY_EN
  logic       resp_par;
`endif

  int checks = 0;
  int failures = 0;

  comp1_agent1_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_id    (req_id),
    .req_data  (req_data),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_id   (resp_id),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .cfg_lat   (cfg_lat),
`ifdef COMP1_AGENT1_RESP_PARITY_EN
    .resp_par  (resp_par),
`endif
    .req_cnt   (req_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold a request until accepted (bounded), return just after the accepting edge.
  task automatic push(input logic [3:0] id, input logic [7:0] d);
    logic ok;
    ok = 1'b0;
    req_id    = id;
    req_data  = d;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        step();
        ok = 1'b1;
        break;
      end
      step();
    end
    req_valid = 1'b0;
    chk($sformatf("push_accept_id%0d", id), 32'(ok), 32'd1);
  endtask

  // Count cycles until resp_valid is seen (bounded).
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!resp_valid && cyc < 50) begin
      step();
      cyc++;
    end
  endtask

  task automatic take_resp();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    int seen;

    // ---------------- Reset state ----------------
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_req_cnt", 32'(req_cnt), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    step();

    // ---------------- 1: basic request, cfg_lat=0 ----------------
    cfg_lat = 4'd0;
    push(4'd3, 8'h10);
    wait_valid(cyc);
    chk("t1_latency", 32'(cyc), 32'd2);
    chk("t1_id", 32'(resp_id), 32'd3);
    chk("t1_data", 32'(resp_data), 32'h11);
    chk("t1_err", 32'(resp_err), 32'd0);
    chk("t1_req_cnt", 32'(req_cnt), 32'd1);
    take_resp();
    chk("t1_valid_drop", 32'(resp_valid), 32'd0);

    // ---------------- 2: wrap ----------------
    push(4'd7, 8'hFF);
    wait_valid(cyc);
    chk("t2_latency", 32'(cyc), 32'd2);
    chk("t2_id", 32'(resp_id), 32'd7);
    chk("t2_data", 32'(resp_data), 32'h00);
    chk("t2_err", 32'(resp_err), 32'd1);
    chk("t2_req_cnt", 32'(req_cnt), 32'd2);
    take_resp();

    // ---------------- 3: fill the FIFO with resp_ready low ----------------
    // Head goes to the holding register, so DEPTH+1 = 5 requests fit.
    for (int i = 0; i < 5; i++) begin
      push(4'(8 + i), 8'(8'h20 + i));
    end
    chk("t3_full_ready", 32'(req_ready), 32'd0);
    chk("t3_req_cnt", 32'(req_cnt), 32'd7);
    req_id    = 4'd13;
    req_data  = 8'h99;
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_blocked_ready%0d", i), 32'(req_ready), 32'd0);
      step();
    end
    req_valid = 1'b0;
    chk("t3_req_cnt_blocked", 32'(req_cnt), 32'd7);
    for (int i = 0; i < 5; i++) begin
      wait_valid(cyc);
      chk($sformatf("t3_resp%0d_seen", i), 32'(cyc < 50), 32'd1);
      chk($sformatf("t3_resp%0d_id", i), 32'(resp_id), 32'(8 + i));
      chk($sformatf("t3_resp%0d_data", i), 32'(resp_data), 32'(8'h21 + i));
      chk($sformatf("t3_resp%0d_err", i), 32'(resp_err), 32'd0);
      if (i == 0) begin
        chk("t3_ready_before_pop", 32'(req_ready), 32'd0);
        take_resp();
        chk("t3_ready_after_pop", 32'(req_ready), 32'd1);
      end else begin
        take_resp();
      end
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid) seen++;
      step();
    end
    chk("t3_no_extra_resp", 32'(seen), 32'd0);

    // ---------------- 4: cfg_lat=5, stall ----------------
    cfg_lat = 4'd5;
    push(4'd2, 8'h40);
    step();
    cfg_lat = 4'd0;  // popped already with 5; must not shorten this wait
    wait_valid(cyc);
    chk("t4_latency", 32'(cyc + 1), 32'd7);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t4_hold_valid%0d", i), 32'(resp_valid), 32'd1);
      chk($sformatf("t4_hold_id%0d", i), 32'(resp_id), 32'd2);
      chk($sformatf("t4_hold_data%0d", i), 32'(resp_data), 32'h41);
      step();
    end
    take_resp();
    chk("t4_valid_drop", 32'(resp_valid), 32'd0);
    chk("t4_req_cnt", 32'(req_cnt), 32'd8);

    // ---------------- 5: reset mid-WAIT ----------------
    cfg_lat = 4'd5;
    push(4'd4, 8'h50);
    push(4'd5, 8'h51);
    push(4'd6, 8'h52);
    chk("t5_pre_rst_cnt", 32'(req_cnt), 32'd11);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_req_ready", 32'(req_ready), 32'd0);
    chk("t5_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("t5_rst_resp_id", 32'(resp_id), 32'd0);
    chk("t5_rst_resp_data", 32'(resp_data), 32'd0);
    chk("t5_rst_resp_err", 32'(resp_err), 32'd0);
    chk("t5_rst_req_cnt", 32'(req_cnt), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("t5_release_ready", 32'(req_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid) seen++;
      step();
    end
    chk("t5_no_stale_resp", 32'(seen), 32'd0);
    chk("t5_req_cnt", 32'(req_cnt), 32'd0);
    cfg_lat = 4'd0;
    push(4'd9, 8'h7F);
    wait_valid(cyc);
    chk("t5_fresh_latency", 32'(cyc), 32'd2);
    chk("t5_fresh_id", 32'(resp_id), 32'd9);
    chk("t5_fresh_data", 32'(resp_data), 32'h80);
    chk("t5_fresh_err", 32'(resp_err), 32'd0);
    chk("t5_fresh_cnt", 32'(req_cnt), 32'd1);
    take_resp();

`ifdef COMP1_AGENT1_RESP_PARITY_EN
    // ---------------- 6: parity ----------------
    push(4'd1, 8'h02);
    wait_valid(cyc);
    chk("t6_data", 32'(resp_data), 32'h03);
    chk("t6_par", 32'(resp_par), 32'd1);
    take_resp();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
